// File: rtl/fetch.sv
// -----------------------------------------------------------------------------
// fetch
//   Front pipeline stage. Holds the fetch program counter, issues one-at-a-time
//   instruction-word reads to instruction memory, buffers returned words in a
//   2-entry prefetch FIFO and hands one instruction per handshake to decode.
//   A PC write from execute redirects fetch and discards wrong-path words,
//   including the data of a request that is still in flight.
//
// Ports
//   i_clk, i_rst_n          clock; asynchronous active-low reset
//   o_mem_req, o_mem_addr   registered read request, held until i_mem_ack
//   i_mem_ack, i_mem_data   read completion and data (same cycle)
//   i_next_ready            decode can take an instruction this cycle
//   o_submit                one-cycle pulse: new instruction on the outputs
//   o_instr_l, o_imm_pass   instruction low half / high half (immediate)
//   o_pc                    address of the instruction on the outputs
//   i_pc_ie, i_pc           redirect strobe and target from execute
// -----------------------------------------------------------------------------
module fetch #(
  parameter int                I_SIZE   = 32,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [I_SIZE-1:0] i_mem_data,
  input  logic              i_next_ready,
  output logic              o_submit,
  output logic [15:0]       o_instr_l,
  output logic [I_SIZE-17:0] o_imm_pass,
  output logic [ADDR_W-1:0] o_pc,
  input  logic              i_pc_ie,
  input  logic [ADDR_W-1:0] i_pc
);

  localparam int ENTRY_W = ADDR_W + I_SIZE;

  // Request tracker. Bit 0 is set in exactly the states with a request on the
  // bus, so o_mem_req comes straight from a flop.
  typedef enum logic [1:0] {
    ST_IDLE       = 2'b00,
    ST_WAIT       = 2'b01,
    ST_WAIT_STALE = 2'b11
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   fetch_pc_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [1:0]          count_reg;
  logic                rd_ptr_reg, wr_ptr_reg;
  logic [ENTRY_W-1:0]  fifo_reg [2];
  logic [ENTRY_W-1:0]  head;
  logic                submit_reg;
  logic [15:0]         instr_l_reg;
  logic [I_SIZE-17:0]  imm_reg;
  logic [ADDR_W-1:0]   pc_reg;

  logic ack_valid;
  logic push;
  logic pop;
  logic space_ok;
  logic issue;

  assign o_mem_req  = state_reg[0];
  assign o_mem_addr = mem_addr_reg;
  assign o_submit   = submit_reg;
  assign o_instr_l  = instr_l_reg;
  assign o_imm_pass = imm_reg;
  assign o_pc       = pc_reg;

  assign head = fifo_reg[rd_ptr_reg];

  // Handshake decisions for this cycle.
  always_comb begin
    // An ack only counts while a request is actually on the bus.
    ack_valid = i_mem_ack && (state_reg != ST_IDLE);
    push      = ack_valid && (state_reg == ST_WAIT) && !i_pc_ie;
    pop       = (count_reg != 2'd0) && i_next_ready && !i_pc_ie;
    // Reserve a FIFO slot for every request: buffered words plus the word
    // landing this cycle must leave room, so an ack never meets a full FIFO.
    space_ok  = (count_reg == 2'd0) || ((count_reg == 2'd1) && !push);
    issue     = !i_pc_ie && space_ok && ((state_reg == ST_IDLE) || ack_valid);
  end

  // Next-state logic for the request tracker.
  always_comb begin
    state_next = state_reg;
    if (i_pc_ie) begin
      // A request still waiting for its ack now carries wrong-path data.
      if ((state_reg != ST_IDLE) && !ack_valid) begin
        state_next = ST_WAIT_STALE;
      end else begin
        state_next = ST_IDLE;
      end
    end else if (issue) begin
      state_next = ST_WAIT;
    end else if (ack_valid) begin
      state_next = ST_IDLE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= ST_IDLE;
      fetch_pc_reg <= RESET_PC;
      mem_addr_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (issue) begin
        mem_addr_reg <= fetch_pc_reg;
      end
      if (i_pc_ie) begin
        fetch_pc_reg <= i_pc;
      end else if (issue) begin
        fetch_pc_reg <= fetch_pc_reg + 1'b1;
      end
    end
  end

  // FIFO bookkeeping; a redirect flushes it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_reg  <= 2'd0;
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
    end else if (i_pc_ie) begin
      count_reg  <= 2'd0;
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      if (push && !pop) begin
        count_reg <= count_reg + 2'd1;
      end else if (!push && pop) begin
        count_reg <= count_reg - 2'd1;
      end
    end
  end

  // FIFO storage: {address, data}; contents are only meaningful under count.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_reg[wr_ptr_reg] <= {mem_addr_reg, i_mem_data};
    end
  end

  // Decode-facing registers hold their value until the next pop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      submit_reg  <= 1'b0;
      instr_l_reg <= '0;
      imm_reg     <= '0;
      pc_reg      <= '0;
    end else begin
      submit_reg <= pop;
      if (pop) begin
        instr_l_reg <= head[15:0];
        imm_reg     <= head[I_SIZE-1:16];
        pc_reg      <= head[ENTRY_W-1:I_SIZE];
      end
    end
  end

endmodule

// File: tb/tb_fetch.sv
module tb_fetch;

  localparam int I_SIZE = 32;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              o_mem_req;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              mem_ack = 1'b0;
  logic [I_SIZE-1:0] mem_data = '0;
  logic              i_next_ready = 1'b0;
  logic              o_submit;
  logic [15:0]       o_instr_l;
  logic [15:0]       o_imm_pass;
  logic [ADDR_W-1:0] o_pc;
  logic              i_pc_ie = 1'b0;
  logic [ADDR_W-1:0] i_pc = '0;

  fetch #(.I_SIZE(I_SIZE), .ADDR_W(ADDR_W), .RESET_PC(16'h0000)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
    .i_mem_ack(mem_ack), .i_mem_data(mem_data),
    .i_next_ready(i_next_ready), .o_submit(o_submit),
    .o_instr_l(o_instr_l), .o_imm_pass(o_imm_pass), .o_pc(o_pc),
    .i_pc_ie(i_pc_ie), .i_pc(i_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // memory model state
  logic [31:0] mem_key;
  int lat_cnt = 0, cur_lat = 0, base_lat = 0, slow_addr = -1, slow_lat = 0;
  bit mem_rand = 0;

  // per-cycle observations
  int cyc = 0;
  logic ack_at_edge, redir_at_edge, ready_at_edge, new_req, held_req;
  logic [15:0] target_at_edge, held_addr;
  logic req_prev = 1'b0;
  logic [15:0] addr_prev = '0;

  // Program image: two fixed words, the rest a keyed function of the address.
  function automatic logic [31:0] mem_word(input logic [15:0] a);
    if (a == 16'h0000) return 32'h0012_3481;
    if (a == 16'h0001) return 32'h0000_0001;
    return {a ^ mem_key[15:0], (~a) + mem_key[31:16]};
  endfunction

  // Decide the memory response for the coming edge.
  task automatic mem_drive();
    if (mem_ack) begin
      mem_ack = 1'b0;
      lat_cnt = 0;
    end else if (o_mem_req) begin
      if (lat_cnt == 0) begin
        if (mem_rand) cur_lat = $urandom_range(0, 3);
        else if (int'(o_mem_addr) == slow_addr) cur_lat = slow_lat;
        else cur_lat = base_lat;
      end
      if (lat_cnt >= cur_lat) begin
        mem_ack  = 1'b1;
        mem_data = mem_word(o_mem_addr);
      end else begin
        lat_cnt++;
      end
    end
  endtask

  // Advance one clock, record what the DUT saw at the edge, then respond.
  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    ack_at_edge    = mem_ack;
    redir_at_edge  = i_pc_ie;
    ready_at_edge  = i_next_ready;
    target_at_edge = i_pc;
    new_req   = o_mem_req && (!req_prev || ack_at_edge);
    held_req  = req_prev && !ack_at_edge;
    held_addr = addr_prev;
    req_prev  = o_mem_req;
    addr_prev = o_mem_addr;
    mem_drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ack = 1'b0; lat_cnt = 0; base_lat = 0; slow_addr = -1; mem_rand = 0;
    i_next_ready = 1'b0; i_pc_ie = 1'b0; i_pc = '0;
    req_prev = 1'b0; addr_prev = '0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (o_submit !== 1'b0) begin errors++; $display("FAIL reset_submit: got %b want 0", o_submit); end
    checks++; if (o_mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", o_mem_req); end
    checks++; if (o_mem_addr !== 16'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", o_mem_addr); end
    checks++; if (o_instr_l !== 16'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", o_instr_l); end
    checks++; if (o_imm_pass !== 16'h0) begin errors++; $display("FAIL reset_imm: got %h want 0", o_imm_pass); end
    checks++; if (o_pc !== 16'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", o_pc); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int nreq, nsub, ack_cyc;
    nreq = 0; nsub = 0; ack_cyc = -1;
    do_reset();
    i_next_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      cycle();
      if (new_req && nreq < 3) begin
        checks++;
        if (o_mem_addr !== 16'(nreq)) begin errors++; $display("FAIL basic_req_addr: got %h want %h", o_mem_addr, 16'(nreq)); end
        nreq++;
      end
      if (o_submit && nsub < 2) begin
        checks++;
        if (o_pc !== 16'(nsub)) begin errors++; $display("FAIL basic_pc: got %h want %h", o_pc, 16'(nsub)); end
        checks++;
        if (nsub == 0) begin
          if (o_instr_l !== 16'h3481 || o_imm_pass !== 16'h0012) begin
            errors++; $display("FAIL basic_data0: got %h_%h want 0012_3481", o_imm_pass, o_instr_l);
          end
          checks++;
          if (cyc - ack_cyc != 2) begin errors++; $display("FAIL basic_latency: got %0d want 2", cyc - ack_cyc); end
        end else begin
          if (o_instr_l !== 16'h0001 || o_imm_pass !== 16'h0000) begin
            errors++; $display("FAIL basic_data1: got %h_%h want 0000_0001", o_imm_pass, o_instr_l);
          end
        end
        nsub++;
      end
      if (mem_ack && ack_cyc < 0) ack_cyc = cyc;
    end
    checks++; if (nreq != 3 || nsub != 2) begin errors++; $display("FAIL basic_progress: got req %0d sub %0d want 3 2", nreq, nsub); end
    $display("test_basic: %0d requests, %0d submits", nreq, nsub);
  endtask

  task automatic test_stall();
    int nacks, nsub, first_req;
    logic [31:0] w;
    nacks = 0; nsub = 0; first_req = -1;
    do_reset();
    repeat (12) begin
      cycle();
      if (ack_at_edge) nacks++;
      if (o_submit) nsub++;
    end
    checks++; if (nacks != 2) begin errors++; $display("FAIL stall_acks: got %0d want 2", nacks); end
    checks++; if (nsub != 0) begin errors++; $display("FAIL stall_submits: got %0d want 0", nsub); end
    checks++; if (o_mem_req !== 1'b0) begin errors++; $display("FAIL stall_req: got %b want 0", o_mem_req); end
    i_next_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (o_submit && nsub < 2) begin
        w = mem_word(16'(nsub));
        checks++;
        if (o_pc !== 16'(nsub) || o_instr_l !== w[15:0] || o_imm_pass !== w[31:16]) begin
          errors++; $display("FAIL stall_order: got pc %h data %h_%h want pc %h data %h", o_pc, o_imm_pass, o_instr_l, 16'(nsub), w);
        end
        nsub++;
      end
      if (new_req && first_req < 0) begin
        first_req = int'(o_mem_addr);
        checks++;
        if (o_mem_addr !== 16'h0002) begin errors++; $display("FAIL stall_resume: got %h want 0002", o_mem_addr); end
      end
    end
    checks++; if (nsub != 2 || first_req < 0) begin errors++; $display("FAIL stall_drain: got sub %0d req %0d want 2 >=0", nsub, first_req); end
    $display("test_stall: drained %0d, resumed at %0d", nsub, first_req);
  endtask

  task automatic test_redirect_stale();
    bit found, got_sub, got_req;
    logic [31:0] w;
    found = 0; got_sub = 0; got_req = 0;
    do_reset();
    i_next_ready = 1'b1;
    slow_addr = 5; slow_lat = 3;
    for (int k = 0; k < 60 && !found; k++) begin
      cycle();
      if (new_req && o_mem_addr == 16'h0005) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL stale_setup: got no request for 0005 want one"); end
    i_pc_ie = 1'b1; i_pc = 16'h0040;
    cycle();
    i_pc_ie = 1'b0;
    checks++; if (o_submit !== 1'b0) begin errors++; $display("FAIL stale_no_submit: got %b want 0", o_submit); end
    checks++; if (o_mem_req !== 1'b1 || o_mem_addr !== 16'h0005) begin errors++; $display("FAIL stale_held: got req %b addr %h want 1 0005", o_mem_req, o_mem_addr); end
    w = mem_word(16'h0040);
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (o_submit && !got_sub) begin
        got_sub = 1; checks++;
        if (o_pc !== 16'h0040 || o_instr_l !== w[15:0] || o_imm_pass !== w[31:16]) begin
          errors++; $display("FAIL stale_first_submit: got pc %h data %h_%h want pc 0040 data %h", o_pc, o_imm_pass, o_instr_l, w);
        end
      end
      if (new_req && !got_req) begin
        got_req = 1; checks++;
        if (o_mem_addr !== 16'h0040) begin errors++; $display("FAIL stale_next_req: got %h want 0040", o_mem_addr); end
      end
    end
    checks++; if (!got_sub || !got_req) begin errors++; $display("FAIL stale_timeout: got sub %0d req %0d want 1 1", got_sub, got_req); end
    slow_addr = -1;
    $display("test_redirect_stale done");
  endtask

  task automatic test_redirect_ack();
    bit found, got_sub;
    logic [31:0] w;
    found = 0; got_sub = 0;
    do_reset();
    i_next_ready = 1'b1; base_lat = 1;
    for (int k = 0; k < 40 && !found; k++) begin
      cycle();
      if (k >= 4 && mem_ack) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL ackredir_setup: got no ack want one"); end
    i_pc_ie = 1'b1; i_pc = 16'h0123;
    cycle();
    i_pc_ie = 1'b0;
    checks++; if (o_submit !== 1'b0) begin errors++; $display("FAIL ackredir_no_submit: got %b want 0", o_submit); end
    checks++; if (o_mem_req !== 1'b0) begin errors++; $display("FAIL ackredir_no_stale: got req %b want 0", o_mem_req); end
    cycle();
    checks++; if (!new_req || o_mem_addr !== 16'h0123) begin errors++; $display("FAIL ackredir_restart: got req %b addr %h want 1 0123", new_req, o_mem_addr); end
    w = mem_word(16'h0123);
    for (int k = 0; k < 20 && !got_sub; k++) begin
      cycle();
      if (o_submit) begin
        got_sub = 1; checks++;
        if (o_pc !== 16'h0123 || o_instr_l !== w[15:0] || o_imm_pass !== w[31:16]) begin
          errors++; $display("FAIL ackredir_submit: got pc %h data %h_%h want pc 0123 data %h", o_pc, o_imm_pass, o_instr_l, w);
        end
      end
    end
    checks++; if (!got_sub) begin errors++; $display("FAIL ackredir_timeout: got no submit want one"); end
    $display("test_redirect_ack done");
  endtask

  task automatic test_redirect_full();
    bit got_sub, got_req;
    logic [31:0] w;
    got_sub = 0; got_req = 0;
    do_reset();
    repeat (10) cycle();
    checks++; if (o_mem_req !== 1'b0) begin errors++; $display("FAIL full_no_issue: got %b want 0", o_mem_req); end
    i_pc_ie = 1'b1; i_pc = 16'h0200; i_next_ready = 1'b1;
    cycle();
    i_pc_ie = 1'b0;
    checks++; if (o_submit !== 1'b0) begin errors++; $display("FAIL full_no_submit: got %b want 0", o_submit); end
    w = mem_word(16'h0200);
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (o_submit && !got_sub) begin
        got_sub = 1; checks++;
        if (o_pc !== 16'h0200 || o_instr_l !== w[15:0] || o_imm_pass !== w[31:16]) begin
          errors++; $display("FAIL full_submit: got pc %h data %h_%h want pc 0200 data %h", o_pc, o_imm_pass, o_instr_l, w);
        end
      end
      if (new_req && !got_req) begin
        got_req = 1; checks++;
        if (o_mem_addr !== 16'h0200) begin errors++; $display("FAIL full_req: got %h want 0200", o_mem_addr); end
      end
    end
    checks++; if (!got_sub || !got_req) begin errors++; $display("FAIL full_timeout: got sub %0d req %0d want 1 1", got_sub, got_req); end
    $display("test_redirect_full done");
  endtask

  task automatic test_wrap();
    int nreq, nsub;
    logic [15:0] exp_a;
    logic [31:0] w;
    nreq = 0; nsub = 0;
    do_reset();
    i_next_ready = 1'b1;
    i_pc_ie = 1'b1; i_pc = 16'hFFFF;
    cycle();
    i_pc_ie = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (new_req && nreq < 2) begin
        exp_a = 16'hFFFF + 16'(nreq);
        checks++;
        if (o_mem_addr !== exp_a) begin errors++; $display("FAIL wrap_req: got %h want %h", o_mem_addr, exp_a); end
        nreq++;
      end
      if (o_submit && nsub < 2) begin
        exp_a = 16'hFFFF + 16'(nsub);
        w = mem_word(exp_a);
        checks++;
        if (o_pc !== exp_a || o_instr_l !== w[15:0] || o_imm_pass !== w[31:16]) begin
          errors++; $display("FAIL wrap_submit: got pc %h data %h_%h want pc %h data %h", o_pc, o_imm_pass, o_instr_l, exp_a, w);
        end
        nsub++;
      end
    end
    checks++; if (nreq != 2 || nsub != 2) begin errors++; $display("FAIL wrap_timeout: got req %0d sub %0d want 2 2", nreq, nsub); end
    $display("test_wrap done");
  endtask

  task automatic test_reset_mid();
    bit found, got_sub, got_req;
    logic [31:0] w;
    found = 0; got_sub = 0; got_req = 0;
    do_reset();
    i_next_ready = 1'b1; base_lat = 3;
    for (int k = 0; k < 40 && !found; k++) begin
      cycle();
      if (o_submit && o_mem_req) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL rstmid_setup: got no submit with request want one"); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (o_mem_req !== 1'b0) begin errors++; $display("FAIL rstmid_req: got %b want 0", o_mem_req); end
    checks++; if (o_submit !== 1'b0) begin errors++; $display("FAIL rstmid_submit: got %b want 0", o_submit); end
    mem_ack = 1'b0; lat_cnt = 0; req_prev = 1'b0; addr_prev = '0; base_lat = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    // Spurious ack while no request is on the bus: must be ignored.
    mem_ack = 1'b1; mem_data = 32'hDEAD_BEEF;
    w = mem_word(16'h0000);
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (new_req && !got_req) begin
        got_req = 1; checks++;
        if (o_mem_addr !== 16'h0000) begin errors++; $display("FAIL rstmid_first_req: got %h want 0000", o_mem_addr); end
      end
      if (o_submit && !got_sub) begin
        got_sub = 1; checks++;
        if (o_pc !== 16'h0000 || o_instr_l !== w[15:0] || o_imm_pass !== w[31:16]) begin
          errors++; $display("FAIL rstmid_first_submit: got pc %h data %h_%h want pc 0000 data %h", o_pc, o_imm_pass, o_instr_l, w);
        end
      end
    end
    checks++; if (!got_sub || !got_req) begin errors++; $display("FAIL rstmid_timeout: got sub %0d req %0d want 1 1", got_sub, got_req); end
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    logic [15:0] exp_pc, exp_req, last_l, last_imm, last_pc, ahead;
    logic [31:0] w;
    int nsub;
    exp_pc = 16'h0000; exp_req = 16'h0000; nsub = 0;
    last_l = '0; last_imm = '0; last_pc = '0;
    do_reset();
    mem_rand = 1;
    i_next_ready = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      cycle();
      if (redir_at_edge) begin
        checks++;
        if (o_submit !== 1'b0 || new_req) begin errors++; $display("FAIL rand_redirect_quiet: got submit %b newreq %b want 0 0", o_submit, new_req); end
        exp_pc = target_at_edge;
        exp_req = target_at_edge;
      end else begin
        if (o_submit) begin
          w = mem_word(exp_pc);
          checks++;
          if (!ready_at_edge || o_pc !== exp_pc || o_instr_l !== w[15:0] || o_imm_pass !== w[31:16]) begin
            errors++; $display("FAIL rand_submit: got pc %h data %h_%h rdy %b want pc %h data %h rdy 1", o_pc, o_imm_pass, o_instr_l, ready_at_edge, exp_pc, w);
          end
          exp_pc = exp_pc + 16'h1;
          nsub++;
        end
        if (new_req) begin
          checks++;
          if (o_mem_addr !== exp_req) begin errors++; $display("FAIL rand_req_addr: got %h want %h", o_mem_addr, exp_req); end
          exp_req = exp_req + 16'h1;
        end
      end
      if (!o_submit) begin
        checks++;
        if (o_instr_l !== last_l || o_imm_pass !== last_imm || o_pc !== last_pc) begin
          errors++; $display("FAIL rand_hold: got %h %h %h want %h %h %h", o_pc, o_imm_pass, o_instr_l, last_pc, last_imm, last_l);
        end
      end
      last_l = o_instr_l; last_imm = o_imm_pass; last_pc = o_pc;
      if (held_req) begin
        checks++;
        if (o_mem_req !== 1'b1 || o_mem_addr !== held_addr) begin
          errors++; $display("FAIL rand_req_stable: got req %b addr %h want 1 %h", o_mem_req, o_mem_addr, held_addr);
        end
      end
      ahead = exp_req - exp_pc;
      checks++;
      if (ahead > 16'd2) begin errors++; $display("FAIL rand_prefetch_depth: got %0d want <=2", ahead); end
      i_next_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) begin
        i_pc_ie = 1'b1;
        i_pc = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'hFFFE + 16'($urandom_range(0, 2));
      end else begin
        i_pc_ie = 1'b0;
      end
    end
    i_pc_ie = 1'b0;
    checks++; if (nsub < 150) begin errors++; $display("FAIL rand_progress: got %0d submits want >=150", nsub); end
    $display("test_random: %0d submits", nsub);
  endtask

  initial begin
    mem_key = $urandom;
    test_reset();
    test_basic();
    test_stall();
    test_redirect_stale();
    test_redirect_ack();
    test_redirect_full();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
